// File: rtl/fntt_seq_ctrl.sv
// Iterative in-place radix-2 DIT forward NTT engine with its sequencing controller.
// Coefficients stream in (natural order) and are stored bit-reversed. LOGN stages of N/2
// butterflies then run on one shared butterfly unit, one per cycle. The N results stream
// out in natural order.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 begin a job (honoured only when idle)
//   omegas [N*W]          twiddle table, slice k = omega^k mod q (latched on start)
//   mod [W]               modulus q (latched on start)
//   in_valid/in_ready     input coefficient handshake, in_data [W]
//   out_valid/out_ready   output coefficient handshake, out_data [W]
//   busy                  high whenever the engine is not idle
//   done                  one-cycle pulse after the last output beat is accepted
module fntt_seq_ctrl #(
    parameter int unsigned N    = 8,
    parameter int unsigned LOGN = 3,
    parameter int unsigned W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] omegas,
    input  logic [W-1:0]   mod,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDrain} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    buf_q   [N];
    logic [W-1:0]    omega_q [N];
    logic [W-1:0]    mod_q;
    logic [LOGN-1:0] idx_q;     // load / drain beat counter
    logic [LOGN-1:0] stage_q;
    logic [LOGN-1:0] bfly_q;    // butterfly index within the current stage
    logic            busy_q;
    logic            done_q;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    // Butterfly addressing: h = 2^s, j = b mod h, p = (b / h) * 2h + j, r = p + h.
    logic [LOGN-1:0] half, jdx, pos_p, pos_r, tw_sh, tw_idx;
    assign half   = LOGN'(1) << stage_q;
    assign jdx    = bfly_q & (half - LOGN'(1));
    assign pos_p  = ((bfly_q >> stage_q) << (stage_q + LOGN'(1))) | jdx;
    assign pos_r  = pos_p | half;  // bit s of p is always 0, so OR equals add
    assign tw_sh  = LOGN'(LOGN - 1) - stage_q;
    assign tw_idx = jdx << tw_sh;

    // Shared butterfly datapath.
    logic [2*W-1:0] prod;
    logic [W-1:0]   tw_val, bf_a, bf_b, bf_t, sum_m, diff_m;
    logic [W:0]     sum_w, diff_w;
    assign tw_val = omega_q[tw_idx];
    assign bf_a   = buf_q[pos_p];
    assign bf_b   = buf_q[pos_r];
    assign prod   = (2*W)'(tw_val) * (2*W)'(bf_b);
    assign bf_t   = W'(prod % (2*W)'(mod_q));
    assign sum_w  = {1'b0, bf_a} + {1'b0, bf_t};
    assign diff_w = {1'b0, bf_a} + {1'b0, mod_q} - {1'b0, bf_t};
    assign sum_m  = (sum_w >= {1'b0, mod_q}) ? W'(sum_w - {1'b0, mod_q}) : W'(sum_w);
    assign diff_m = (diff_w >= {1'b0, mod_q}) ? W'(diff_w - {1'b0, mod_q}) : W'(diff_w);

    logic last_beat, last_bfly;
    assign last_beat = (idx_q == LOGN'(N - 1));
    assign last_bfly = (stage_q == LOGN'(LOGN - 1)) && (bfly_q == LOGN'(N / 2 - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  if (in_valid && last_beat) state_d = StCalc;
            StCalc:  if (last_bfly) state_d = StDrain;
            StDrain: if (out_ready && last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_q == StDrain) && out_ready && last_beat;
            unique case (state_q)
                StIdle: begin
                    idx_q   <= '0;
                    stage_q <= '0;
                    bfly_q  <= '0;
                end
                StLoad:  if (in_valid) idx_q <= idx_q + LOGN'(1);  // wraps to 0 after N-1
                StCalc: begin
                    if (bfly_q == LOGN'(N / 2 - 1)) begin
                        bfly_q  <= '0;
                        stage_q <= stage_q + LOGN'(1);
                    end else begin
                        bfly_q <= bfly_q + LOGN'(1);
                    end
                end
                StDrain: if (out_ready) idx_q <= idx_q + LOGN'(1);
                default: ;
            endcase
        end
    end

    // Data storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int k = 0; k < N; k++) omega_q[k] <= omegas[k*W +: W];
                    mod_q <= mod;
                end
            end
            StLoad:  if (in_valid) buf_q[bitrev(idx_q)] <= in_data;
            StCalc: begin
                buf_q[pos_p] <= sum_m;
                buf_q[pos_r] <= diff_m;
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? buf_q[idx_q] : '0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fntt_seq_ctrl.sv
// Self-checking bench for fntt_seq_ctrl: expected output beats are queued when a job is
// launched and popped as the engine hands out each beat.
module tb_fntt_seq_ctrl;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int W    = 8;
    localparam int Q    = 17;

    typedef logic [W-1:0] vec_t [N];

    logic           clk = 1'b0;
    logic           rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [N*W-1:0] omegas;
    logic [W-1:0]   mod, in_data, out_data;

    always #5 clk = ~clk;

    fntt_seq_ctrl #(.N(N), .LOGN(LOGN), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .omegas    (omegas),
        .mod       (mod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb [$];
    vec_t tbl = '{8'd1, 8'd9, 8'd13, 8'd15, 8'd16, 8'd8, 8'd4, 8'd2};

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Direct O(N^2) transform X[k] = sum x[n] * omega^(n*k) mod q.
    function automatic vec_t ntt_ref(input vec_t x);
        vec_t r;
        for (int k = 0; k < N; k++) begin
            int unsigned acc = 0;
            for (int n = 0; n < N; n++)
                acc = (acc + int'(x[n]) * int'(tbl[(n * k) % N])) % Q;
            r[k] = W'(acc);
        end
        return r;
    endfunction

    task automatic launch();
        @(negedge clk);
        for (int k = 0; k < N; k++) omegas[k*W +: W] = tbl[k];
        mod   = W'(Q);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        omegas = {$urandom, $urandom};  // table may change after the start cycle
        mod    = W'($urandom);
    endtask

    task automatic run_job(input string tag, input vec_t x, input vec_t exp,
                           input int vpct, input int rpct, input int spct);
        int   idx   = 0;
        int   calc  = 0;
        int   dones = 0;
        int   cyc   = 0;
        logic held_v = 1'b0;
        logic [W-1:0] held_d = '0;
        logic [W-1:0] e;
        for (int k = 0; k < N; k++) sb.push_back(exp[k]);
        launch();
        #1;
        check_eq({tag, "_busy_start"}, int'(busy), 1);
        while (sb.size() > 0 && cyc < 3000) begin
            in_valid  = (idx < N) && (($urandom % 100) < vpct);
            in_data   = (idx < N) ? x[idx] : W'($urandom);
            out_ready = ($urandom % 100) < rpct;
            start     = ($urandom % 100) < spct;
            #1;
            if (busy && !in_ready && !out_valid) calc++;
            if (held_v) check_eq({tag, "_hold"}, int'(out_data), int'(held_d));
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                check_eq({tag, "_out"}, int'(out_data), int'(e));
                check_eq({tag, "_lt_q"}, int'(out_data < W'(Q)), 1);
            end
            if (done) dones++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 3000) begin
            check_eq({tag, "_timeout_left"}, sb.size(), 0);
            sb.delete();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        #1;
        if (done) dones++;
        check_eq({tag, "_busy_end"}, int'(busy), 0);
        check_eq({tag, "_in_ready_idle"}, int'(in_ready), 0);
        @(negedge clk);
        #1;
        if (done) dones++;
        check_eq({tag, "_done_cnt"}, dones, 1);
        check_eq({tag, "_calc_cycles"}, calc, 12);
        check_eq({tag, "_still_idle"}, int'(busy), 0);
    endtask

    task automatic reset_mid_calc(input vec_t x);
        int cyc = 0;
        int idx = 0;
        launch();
        while (idx < N && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = x[idx];
            #1;
            if (in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_eq("busy_mid_calc", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_done", int'(done), 0);
        rst = 1'b0;
    endtask

    initial begin
        vec_t c1, c1_exp, imp, imp_exp, ones, ones_exp, maxv, maxv_exp, rnd;
        c1       = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        c1_exp   = '{8'd6, 8'd7, 8'd7, 8'd9, 8'd2, 8'd5, 8'd6, 8'd0};
        imp      = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        imp_exp  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        ones     = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        ones_exp = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        maxv     = '{8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
        maxv_exp = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; mod = '0; omegas = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_in_ready", int'(in_ready), 0);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_out_data", int'(out_data), 0);
        rst = 1'b0;

        run_job("case1", c1, c1_exp, 100, 100, 0);
        run_job("impulse", imp, imp_exp, 100, 100, 0);
        run_job("ones", ones, ones_exp, 100, 100, 0);
        run_job("qminus1", maxv, maxv_exp, 100, 100, 0);
        run_job("case1_stall", c1, c1_exp, 50, 50, 0);
        run_job("case1_start", c1, c1_exp, 70, 60, 30);
        reset_mid_calc(ones);
        run_job("case1_after_rst", c1, c1_exp, 100, 100, 0);
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < N; k++) rnd[k] = W'($urandom_range(Q - 1, 0));
            run_job("random", rnd, ntt_ref(rnd), 60, 60, 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
